// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder.
// Holds the I/O register offsets, the TX status word layout and the default
// sizes of the data RAM and transmit FIFO.
package data_mem_responder_pkg;

  // Defaults for the responder parameters.
  localparam int unsigned DataMemWordsDefault = 1024;
  localparam int unsigned TxFifoDepthDefault  = 8;

  // CPU data bus geometry; the top address bit selects the I/O space.
  localparam int unsigned DataAddrPath = 16;
  localparam int unsigned DataPath     = 32;

  // I/O register offsets (dataAddr[3:0]).
  localparam logic [3:0] IoOffLed      = 4'h0;
  localparam logic [3:0] IoOffTxData   = 4'h4;
  localparam logic [3:0] IoOffTxStatus = 4'h8;
  localparam logic [3:0] IoOffCycle    = 4'hC;

  // TX status word as seen by the CPU.
  typedef struct packed {
    logic [23:0] rsvd_hi;
    logic [3:0]  count;
    logic        rsvd_lo;
    logic        overflow;
    logic        full;
    logic        empty;
  } tx_status_t;

endpackage

// File: rtl/data_mem_responder_tx_fifo.sv
// TxFifo: byte-wide transmit FIFO with registered occupancy count.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset (discards contents)
//   push_i, data_i - push request and byte; accepted if not full or popping
//   pop_i          - pop request; caller only asserts it when non-empty
//   full_o, empty_o, count_o - occupancy flags and count
//   head_o         - byte at the head; 0 when empty
module TxFifo #(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic [7:0]               head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      mem_q [Depth];

  logic push_ok;
  logic pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Full is fine to push into when the head leaves on the same edge.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-side memory and I/O for a single-cycle CPU.
// Loads are combinational; stores commit on the rising clock edge.
// Address bit [DataAddrPath-1] = 0 selects word RAM (aliased by depth),
// = 1 selects I/O by dataAddr[3:0]: LED, TX data push, TX status, cycle counter.
// Ports:
//   clk, rst                   - clock, asynchronous active-low reset
//   dataAddr/dataWrData/dataWrEnable/dataRdData - CPU data port
//   led                        - LED register
//   txData/txValid/txReady     - transmit FIFO head stream
// Build option: define DATA_MEM_CYCLE_COUNTER_EN to include the cycle
// counter at offset 0xC; otherwise that offset reads 0 and ignores writes.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DATA_MEM_WORDS = DataMemWordsDefault,
  parameter int unsigned TX_FIFO_DEPTH  = TxFifoDepthDefault
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DataAddrPath-1:0] dataAddr,
  input  logic [DataPath-1:0]     dataWrData,
  input  logic                    dataWrEnable,
  output logic [DataPath-1:0]     dataRdData,
  output logic [7:0]              led,
  output logic [7:0]              txData,
  output logic                    txValid,
  input  logic                    txReady
);

  localparam int unsigned RamAw = $clog2(DATA_MEM_WORDS);
  localparam int unsigned CntW  = $clog2(TX_FIFO_DEPTH) + 1;

  logic [DataPath-1:0] ram_q [DATA_MEM_WORDS];

  logic             is_io;
  logic [RamAw-1:0] ram_idx;
  logic [3:0]       io_off;
  logic             ram_we, led_we, tx_push, status_we;
  logic [7:0]       led_q, led_d;
  logic             overflow_q, overflow_d;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [CntW-1:0]  fifo_count;
  tx_status_t       tx_status;
  logic [DataPath-1:0] cyc_rdata;
  logic             unused_addr;

  assign is_io   = dataAddr[DataAddrPath-1];
  assign ram_idx = dataAddr[RamAw+1:2];
  assign io_off  = dataAddr[3:0];
  // Upper RAM address bits alias by design.
  assign unused_addr = ^dataAddr;

  assign ram_we    = dataWrEnable && !is_io;
  assign led_we    = dataWrEnable && is_io && (io_off == IoOffLed);
  assign tx_push   = dataWrEnable && is_io && (io_off == IoOffTxData);
  assign status_we = dataWrEnable && is_io && (io_off == IoOffTxStatus);

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= dataWrData;
  end

  // LED and sticky overflow.
  always_comb begin
    led_d      = led_q;
    overflow_d = overflow_q;
    if (led_we) led_d = dataWrData[7:0];
    if (status_we) overflow_d = 1'b0;
    if (tx_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      led_q      <= led_d;
      overflow_q <= overflow_d;
    end
  end

  assign led = led_q;

  assign txValid  = !fifo_empty;
  assign fifo_pop = txValid && txReady;

  TxFifo #(
    .Depth (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (tx_push),
    .data_i  (dataWrData[7:0]),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (txData)
  );

`ifdef DATA_MEM_CYCLE_COUNTER_EN
  logic                cyc_we;
  logic [DataPath-1:0] cyc_q, cyc_d;

  assign cyc_we = dataWrEnable && is_io && (io_off == IoOffCycle);

  // CPU load beats the free-running increment.
  always_comb begin
    cyc_d = cyc_q + DataPath'(1);
    if (cyc_we) cyc_d = dataWrData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cyc_q <= '0;
    else      cyc_q <= cyc_d;
  end

  assign cyc_rdata = cyc_q;
`else
  assign cyc_rdata = '0;
`endif

  always_comb begin
    tx_status          = '0;
    tx_status.count    = 4'(fifo_count);
    tx_status.overflow = overflow_q;
    tx_status.full     = fifo_full;
    tx_status.empty    = fifo_empty;
  end

  // Read mux; TX data offset and unmapped offsets read 0.
  always_comb begin
    dataRdData = '0;
    if (!is_io) begin
      dataRdData = ram_q[ram_idx];
    end else begin
      case (io_off)
        IoOffLed:      dataRdData = {24'h0, led_q};
        IoOffTxStatus: dataRdData = tx_status;
        IoOffCycle:    dataRdData = cyc_rdata;
        default:       dataRdData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (default parameters).
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        tx_ready;
  logic [31:0] rdata;
  logic [7:0]  led;
  logic [7:0]  tx_data;
  logic        tx_valid;

  int n_total = 0;
  int n_bad   = 0;

  data_mem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .dataAddr     (addr),
    .dataWrData   (wdata),
    .dataWrEnable (we),
    .dataRdData   (rdata),
    .led          (led),
    .txData       (tx_data),
    .txValid      (tx_valid),
    .txReady      (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    cyc();
    we    = 1'b0;
  endtask

  task automatic rd_set(input logic [15:0] a);
    addr = a;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; we = 1'b0; addr = '0; wdata = '0; tx_ready = 1'b0;
    #2;
    n_total++;
    if (led !== 8'h00) begin n_bad++; $display("FAIL reset_led got=%h exp=00", led); end
    n_total++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      n_bad++; $display("FAIL reset_tx got=%b/%h exp=0/00", tx_valid, tx_data);
    end
    rd_set(16'h8008);
    n_total++;
    if (rdata !== 32'h1) begin n_bad++; $display("FAIL reset_status got=%h exp=1", rdata); end
    rd_set(16'h800C);
    n_total++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_counter got=%h exp=0", rdata); end
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_ram();
    wr(16'h0010, 32'hDEADBEEF);
    wr(16'h0014, 32'h12345678);
    rd_set(16'h0010);
    n_total++;
    if (rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ram_rd got=%h exp=deadbeef", rdata); end
    rd_set(16'h1010);
    n_total++;
    if (rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ram_alias got=%h exp=deadbeef", rdata); end
    rd_set(16'h0013);
    n_total++;
    if (rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ram_byteoff got=%h exp=deadbeef", rdata); end
    rd_set(16'h0014);
    n_total++;
    if (rdata !== 32'h12345678) begin n_bad++; $display("FAIL ram_rd2 got=%h exp=12345678", rdata); end
    rd_set(16'h8004);
    n_total++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL txdata_rd got=%h exp=0", rdata); end
    rd_set(16'h8001);
    n_total++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL unmapped_rd got=%h exp=0", rdata); end
  endtask

  task automatic test_led();
    addr = 16'h8000; wdata = 32'h000000A5; we = 1'b1;
    #1;
    n_total++;
    if (led !== 8'h00) begin n_bad++; $display("FAIL led_early got=%h exp=00", led); end
    cyc();
    we = 1'b0;
    n_total++;
    if (led !== 8'hA5) begin n_bad++; $display("FAIL led_wr got=%h exp=a5", led); end
    rd_set(16'h8000);
    n_total++;
    if (rdata !== 32'h000000A5) begin n_bad++; $display("FAIL led_rd got=%h exp=a5", rdata); end
    wr(16'h8001, 32'hFF);
    n_total++;
    if (led !== 8'hA5) begin n_bad++; $display("FAIL unmapped_wr got=%h exp=a5", led); end
    rst = 1'b0;
    #1;
    n_total++;
    if (led !== 8'h00) begin n_bad++; $display("FAIL led_rst got=%h exp=00", led); end
    rd_set(16'h8000);
    n_total++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL led_rst_rd got=%h exp=0", rdata); end
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_overflow();
    tx_ready = 1'b0;
    addr = 16'h8004; wdata = 32'h01; we = 1'b1;
    #1;
    n_total++;
    if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL valid_comb got=%b exp=0", tx_valid); end
    cyc();
    n_total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
      n_bad++; $display("FAIL valid_next got=%b/%h exp=1/01", tx_valid, tx_data);
    end
    for (int i = 2; i <= 9; i++) begin
      wdata = i;
      cyc();
    end
    we = 1'b0;
    rd_set(16'h8008);
    n_total++;
    if (rdata !== 32'h86) begin n_bad++; $display("FAIL status_ovf got=%h exp=86", rdata); end
    n_total++;
    if (tx_data !== 8'h01) begin n_bad++; $display("FAIL head_stable got=%h exp=01", tx_data); end
    wr(16'h8008, 32'h0);
    rd_set(16'h8008);
    n_total++;
    if (rdata !== 32'h82) begin n_bad++; $display("FAIL status_clr got=%h exp=82", rdata); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q [8];
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h55};
    addr = 16'h8004; wdata = 32'h55; we = 1'b1; tx_ready = 1'b1;
    cyc();
    we = 1'b0; tx_ready = 1'b0;
    rd_set(16'h8008);
    n_total++;
    if (rdata !== 32'h82) begin n_bad++; $display("FAIL push_pop_status got=%h exp=82", rdata); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
        n_bad++; $display("FAIL pop_seq[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_q[i]);
      end
      if (i == 1) begin
        rd_set(16'h8008);
        n_total++;
        if (rdata !== 32'h70) begin n_bad++; $display("FAIL pop_count got=%h exp=70", rdata); end
      end
      cyc();
    end
    tx_ready = 1'b0;
    n_total++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      n_bad++; $display("FAIL drained got=%b/%h exp=0/00", tx_valid, tx_data);
    end
    rd_set(16'h8008);
    n_total++;
    if (rdata !== 32'h01) begin n_bad++; $display("FAIL drained_status got=%h exp=01", rdata); end
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    wr(16'h8004, 32'h11);
    wr(16'h8004, 32'h22);
    n_total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
      n_bad++; $display("FAIL mid_pre got=%b/%h exp=1/11", tx_valid, tx_data);
    end
    rst = 1'b0;
    #1;
    n_total++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      n_bad++; $display("FAIL mid_rst got=%b/%h exp=0/00", tx_valid, tx_data);
    end
    rd_set(16'h8008);
    n_total++;
    if (rdata !== 32'h01) begin n_bad++; $display("FAIL mid_status got=%h exp=01", rdata); end
    cyc();
    rst = 1'b1;
    cyc();
    n_total++;
    if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL mid_after got=%b exp=0", tx_valid); end
    rd_set(16'h0010);
    n_total++;
    if (rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ram_keep got=%h exp=deadbeef", rdata); end
  endtask

  task automatic test_counter();
`ifdef DATA_MEM_CYCLE_COUNTER_EN
    addr = 16'h800C; wdata = 32'hFFFFFFFE; we = 1'b1;
    cyc();
    we = 1'b0;
    #1;
    n_total++;
    if (rdata !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL cnt_load got=%h exp=fffffffe", rdata); end
    cyc();
    n_total++;
    if (rdata !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL cnt_inc got=%h exp=ffffffff", rdata); end
    cyc();
    n_total++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL cnt_wrap got=%h exp=0", rdata); end
`else
    wr(16'h800C, 32'hFFFFFFFE);
    rd_set(16'h800C);
    n_total++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL cnt_off got=%h exp=0", rdata); end
    cyc();
    n_total++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL cnt_off2 got=%h exp=0", rdata); end
`endif
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_counter();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- DATA_MEM_WORDS, 1024, RAM depth in 32-bit words; power of 2.
- TX_FIFO_DEPTH, 8, transmit FIFO entries; power of 2.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock.
- rst, in, 1, asynchronous, active-low reset.
- dataAddr, in, DataAddrPath, CPU byte address.
- dataWrData, in, DataPath (32), CPU store data.
- dataWrEnable, in, 1, CPU store strobe.
- dataRdData, out, DataPath (32), load data to CPU.
- led, out, 8, LED register.
- txData, out, 8, FIFO head byte.
- txValid, out, 1, FIFO non-empty.
- txReady, in, 1, consumer accepts head.

Function
REQ-003 The block SHALL drive dataRdData combinationally from dataAddr in the same cycle; the single-cycle CPU consumes it with zero latency.
REQ-004 The block SHALL perform writes at posedge clk when dataWrEnable=1.
REQ-005 Bit DATA_ADDR_WIDTH-1 of dataAddr = 0 SHALL select RAM at word index dataAddr[log2(DATA_MEM_WORDS)+1:2]; higher bits are ignored (aliasing wrap); bits [1:0] are ignored.
REQ-006 Bit DATA_ADDR_WIDTH-1 = 1 SHALL select I/O by offset dataAddr[3:0]: 0x0 LED (RW, bits [7:0]); 0x4 TX data (W pushes byte [7:0], R returns 0); 0x8 TX status (R); 0xC cycle counter (RW).
REQ-007 TX status SHALL read as {24'b0, count[3:0], 1'b0, overflow, full, empty}; a write of any value to 0x8 SHALL clear overflow.
REQ-008 Unmapped I/O reads SHALL return 0; unmapped writes SHALL be ignored.
REQ-009 The FIFO SHALL pop on posedge when txValid && txReady.
REQ-010 A push SHALL be accepted when not full, or when full with a pop in the same cycle.
REQ-011 A push to a full FIFO without a pop SHALL be dropped and SHALL set sticky overflow.
REQ-012 A push into an empty FIFO SHALL raise txValid in the next cycle, not combinationally; txData SHALL be stable while txValid && !txReady.
REQ-013 count SHALL change by +1 for a push only, -1 for a pop only, and 0 for both in the same cycle.
REQ-014 The cycle counter SHALL increment by 1 per cycle and wrap from 0xFFFFFFFF to 0; a CPU write SHALL load dataWrData, taking priority over the increment.

Reset
REQ-015 While rst=0: led=0, FIFO empty (txValid=0, count=0), overflow=0, counter=0; txData SHALL be 0 when empty.
REQ-016 Reset assertion mid-transfer SHALL discard FIFO contents immediately.
REQ-017 RAM contents SHALL NOT be reset.
REQ-018 dataRdData SHALL remain combinational during reset and SHALL reflect the reset register values.

Configuration
REQ-019 With macro DATA_MEM_CYCLE_COUNTER_EN defined, the counter at offset 0xC SHALL exist per REQ-014.
REQ-020 Without DATA_MEM_CYCLE_COUNTER_EN, no counter flops SHALL exist, offset 0xC SHALL read 0, and writes to 0xC SHALL be ignored.

Structure
REQ-021 The I/O offset constants, the TX status packed struct, and the defaults of DATA_MEM_WORDS and TX_FIFO_DEPTH SHALL live in the shared Types package.
REQ-022 The FIFO SHALL be a sub-module named TxFifo, with push/pop/full/empty/count/head signals and its own asynchronous active-low reset.
REQ-023 RAM, address decode and read mux SHALL live in data_mem_responder.

Verification (DATA_ADDR_WIDTH=16, I/O base 0x8000)
REQ-024 Store 0xDEADBEEF to 0x0010, then load 0x0010 and its alias 0x0010+4*DATA_MEM_WORDS -> both return 0xDEADBEEF in the same cycle as the address.
REQ-025 Write 0xA5 to 0x8000 -> led=0xA5 next cycle; load 0x8000 returns 0x000000A5; pulse rst=0 -> led=0 immediately.
REQ-026 With txReady=0, push bytes 0x01..0x09 to 0x8004 -> status 0x86 (count 8, overflow, full); txData=0x01; write 0x8008 -> status 0x82.
REQ-027 FIFO full with txReady=1 and a push of 0x55 in the same cycle -> count stays 8; the popped sequence ends with 0x55; no overflow.
REQ-028 Macro defined: write 0xFFFFFFFE to 0x800C, then read on the following two cycles -> 0xFFFFFFFF, then 0x00000000. Macro undefined: 0x800C reads 0 after a write.
